// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: RX FIFO / holding register, line-status bits,
// trigger-level indication and character-timeout FSM.
module uart_rx_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pe_in,
  input  logic       fe_in,
  input  logic       bi_in,
  input  logic       fifo_en,
  input  logic       rx_fifo_rst,
  input  logic [1:0] rx_trig,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       stb,
  input  logic       rd,
  input  logic       lsr_rd,
  output logic [7:0] dout,
  output logic       dr,
  output logic       oe,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       fifo_err,
  output logic [4:0] count,
  output logic       trig_hit,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} to_state_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [10:0]   mem_q [DEPTH];
  logic [10:0]   hold_q, hold_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d, err_q, err_d, lvl;
  logic          oe_q, oe_d, trig_q, trig_d, fen_q;
  logic          flush, do_pop, do_push, ovr, to_clr;
  logic [10:0]   wentry, head;
  logic [3:0]    bits;
  logic [9:0]    limit, tcnt_q;
  logic          timeout_q;
  to_state_e     st_q;

  // Head entry comes from whichever store the registered mode last filled.
  assign head   = fen_q ? mem_q[rp_q] : hold_q;
  assign wentry = {bi_in, fe_in, pe_in, din};

  always_comb begin
    flush   = rx_fifo_rst | (fifo_en != fen_q);
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    err_d   = err_q;
    hold_d  = hold_q;
    do_pop  = 1'b0;
    do_push = 1'b0;
    ovr     = 1'b0;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      err_d   = '0;
    end else if (fifo_en) begin
      do_pop  = rd && (count_q != '0);
      do_push = push && ((count_q != FULL) || do_pop);
      ovr     = push && !do_push;
      if (do_pop)  rp_d = rp_q + AW'(1);
      if (do_push) wp_d = wp_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      err_d   = err_q + (AW+1)'(do_push & (|wentry[10:8]))
                      - (AW+1)'(do_pop & (|head[10:8]));
    end else begin
      if (push) begin
        hold_d  = wentry;
        count_d = (AW+1)'(1);
        ovr     = (count_q != '0) && !rd;
      end else if (rd && (count_q != '0)) begin
        count_d = '0;
      end
    end
    oe_d = ovr ? 1'b1 : (lsr_rd ? 1'b0 : oe_q);
    case (rx_trig)
      2'b00:   lvl = (AW+1)'(1);
      2'b01:   lvl = (AW+1)'(4);
      2'b10:   lvl = (AW+1)'(8);
      default: lvl = (AW+1)'(14);
    endcase
    // Trigger follows the registered count, so it lags a count change by one clk.
    trig_d = fifo_en ? (count_q >= lvl) : (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      err_q   <= '0;
      oe_q    <= 1'b0;
      trig_q  <= 1'b0;
      fen_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
      trig_q  <= trig_d;
      fen_q   <= fifo_en;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (do_push) mem_q[wp_q] <= wentry;
  end

  // Character time in bits; the limit is four character times of 16x ticks.
  assign bits   = 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
  assign limit  = {bits, 6'b000000};
  assign to_clr = push | rd | flush | !fifo_en | (count_q == '0);

  always_ff @(posedge clk) begin
    if (rst || to_clr) begin
      st_q      <= IDLE;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE:  st_q <= COUNT;
        COUNT: begin
          if (baud_pulse) begin
            if (tcnt_q >= limit - 10'd1) begin
              st_q      <= EXPIRED;
              timeout_q <= 1'b1;
            end else begin
              tcnt_q <= tcnt_q + 10'd1;
            end
          end
        end
        default: st_q <= EXPIRED;
      endcase
    end
  end

  assign dout     = head[7:0];
  assign dr       = (count_q != '0);
  assign pe       = dr & head[8];
  assign fe       = dr & head[9];
  assign bi       = dr & head[10];
  assign oe       = oe_q;
  assign fifo_err = fifo_en & (err_q != '0);
  assign count    = count_q;
  assign trig_hit = trig_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized and directed bench for uart_rx_ctrl against a queue-based reference model.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst, baud_pulse, push, pe_in, fe_in, bi_in, fifo_en, rx_fifo_rst;
  logic       pen, stb, rd, lsr_rd;
  logic [7:0] din;
  logic [1:0] rx_trig, wls;
  logic [7:0] dout;
  logic       dr, oe, pe, fe, bi, fifo_err, trig_hit, timeout;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  logic [10:0] mq[$];
  logic        m_oe, m_trig, m_to, m_armed, m_fen;
  int          m_ticks;

  uart_rx_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .push(push), .din(din),
    .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in), .fifo_en(fifo_en),
    .rx_fifo_rst(rx_fifo_rst), .rx_trig(rx_trig), .wls(wls), .pen(pen), .stb(stb),
    .rd(rd), .lsr_rd(lsr_rd), .dout(dout), .dr(dr), .oe(oe), .pe(pe), .fe(fe),
    .bi(bi), .fifo_err(fifo_err), .count(count), .trig_hit(trig_hit), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int trig_level(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 14;
    endcase
  endfunction

  // Reference behaviour evaluated with the inputs sampled at a rising edge.
  task automatic model_step();
    int cnt_pre, lim;
    bit flush, clr, ov;
    logic [10:0] e;
    if (rst) begin
      mq.delete();
      m_oe = 0; m_trig = 0; m_to = 0; m_armed = 0; m_ticks = 0; m_fen = 0;
      return;
    end
    cnt_pre = mq.size();
    lim     = 64 * (7 + int'(wls) + int'(pen) + int'(stb));
    flush   = rx_fifo_rst || (fifo_en != m_fen);
    clr     = push || rd || flush || !fifo_en || (cnt_pre == 0);
    if (clr) begin
      m_armed = 0; m_ticks = 0; m_to = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (!m_to && baud_pulse) begin
      m_ticks++;
      if (m_ticks >= lim) m_to = 1;
    end
    ov = 0;
    e  = {bi_in, fe_in, pe_in, din};
    if (flush) begin
      mq.delete();
    end else if (fifo_en) begin
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < 16) mq.push_back(e);
        else ov = 1;
      end
    end else begin
      if (push) begin
        ov = (mq.size() > 0) && !rd;
        mq.delete();
        mq.push_back(e);
      end else if (rd) begin
        mq.delete();
      end
    end
    if (ov) m_oe = 1;
    else if (lsr_rd) m_oe = 0;
    m_trig = fifo_en ? (cnt_pre >= trig_level(rx_trig)) : (cnt_pre != 0);
    m_fen  = fifo_en;
  endtask

  task automatic compare_all();
    logic [10:0] h;
    bit anyf;
    h = (mq.size() > 0) ? mq[0] : 11'h0;
    anyf = 0;
    foreach (mq[i]) if (|mq[i][10:8]) anyf = 1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("dr", 32'(dr), 32'(mq.size() != 0));
    if (mq.size() > 0) chk("dout", 32'(dout), 32'(h[7:0]));
    chk("pe", 32'(pe), 32'(h[8]));
    chk("fe", 32'(fe), 32'(h[9]));
    chk("bi", 32'(bi), 32'(h[10]));
    chk("oe", 32'(oe), 32'(m_oe));
    chk("fifo_err", 32'(fifo_err), 32'(fifo_en && anyf));
    chk("trig_hit", 32'(trig_hit), 32'(m_trig));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    push = 0; rd = 0; lsr_rd = 0; rx_fifo_rst = 0; baud_pulse = 0; rst = 0;
    pe_in = 0; fe_in = 0; bi_in = 0;
  endtask

  task automatic push_ch(input logic [7:0] c, input logic [2:0] flags, input logic with_rd);
    push = 1; din = c; {bi_in, fe_in, pe_in} = flags; rd = with_rd;
    cyc();
  endtask

  task automatic rd_ch();
    rd = 1;
    cyc();
  endtask

  initial begin
    int np;
    bit seen;
    rst = 1; baud_pulse = 0; push = 0; din = 0; pe_in = 0; fe_in = 0; bi_in = 0;
    fifo_en = 1; rx_fifo_rst = 0; rx_trig = 2'b01; wls = 2'b11; pen = 0; stb = 0;
    rd = 0; lsr_rd = 0;
    @(negedge clk);
    rst = 1; cyc();
    rst = 1; cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_trig", 32'(trig_hit), 0);
    cyc();

    for (int i = 0; i < 4; i++) begin
      push_ch(8'h41 + 8'(i), 3'b000, 0);
      chk("push_count", 32'(count), 32'(i + 1));
    end
    chk("trig_lag", 32'(trig_hit), 0);
    cyc();
    chk("trig_at4", 32'(trig_hit), 1);
    for (int i = 0; i < 4; i++) begin
      chk("order", 32'(dout), 32'(8'h41 + 8'(i)));
      rd_ch();
    end
    chk("drained_dr", 32'(dr), 0);
    cyc();
    chk("drained_trig", 32'(trig_hit), 0);

    for (int i = 0; i < 16; i++) push_ch(8'(i), 3'b000, 0);
    push_ch(8'hAA, 3'b000, 0);
    chk("ovr_oe", 32'(oe), 1);
    chk("ovr_count", 32'(count), 16);
    lsr_rd = 1; cyc();
    chk("lsr_clr", 32'(oe), 0);
    push_ch(8'hBB, 3'b000, 1);
    chk("full_rdpush_oe", 32'(oe), 0);
    chk("full_rdpush_cnt", 32'(count), 16);
    for (int i = 0; i < 15; i++) rd_ch();
    chk("last_new", 32'(dout), 32'h0BB);
    rd_ch();

    push_ch(8'h01, 3'b000, 0);
    push_ch(8'h55, 3'b001, 0);
    chk("ferr_set", 32'(fifo_err), 1);
    push_ch(8'h02, 3'b000, 0);
    push_ch(8'h03, 3'b000, 0);
    chk("pe_not_head", 32'(pe), 0);
    rd_ch();
    chk("pe_head", 32'(pe), 1);
    rd_ch();
    chk("ferr_clr", 32'(fifo_err), 0);
    rd_ch(); rd_ch();

    wls = 2'b11; pen = 0; stb = 0;
    push_ch(8'h77, 3'b000, 0);
    np = 0; seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      baud_pulse = (i % 3 == 2);
      if (baud_pulse) np++;
      cyc();
      if (timeout) seen = 1;
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_640", 32'(np), 640);
    rd_ch();
    chk("to_clr", 32'(timeout), 0);
    chk("to_rd_count", 32'(count), 0);

    fifo_en = 0; cyc();
    push_ch(8'h12, 3'b000, 0);
    push_ch(8'h34, 3'b000, 0);
    chk("nf_oe", 32'(oe), 1);
    chk("nf_dout", 32'(dout), 32'h34);
    chk("nf_count", 32'(count), 1);
    fifo_en = 1; cyc();
    chk("sw_count", 32'(count), 0);
    chk("sw_oe", 32'(oe), 1);

    for (int i = 0; i < 7; i++) push_ch(8'(8'h60 + i), 3'(i), 0);
    for (int i = 0; i < 20; i++) begin baud_pulse = 1; cyc(); end
    rst = 1; cyc();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_oe", 32'(oe), 0);
    chk("mid_rst_ferr", 32'(fifo_err), 0);
    cyc();
    rx_fifo_rst = 1; push_ch(8'h99, 3'b000, 0);
    chk("flush_push", 32'(count), 0);

    for (int i = 0; i < 4000; i++) begin
      push        = ($urandom_range(0, 3) == 0);
      rd          = ($urandom_range(0, 4) == 0);
      lsr_rd      = ($urandom_range(0, 15) == 0);
      baud_pulse  = ($urandom_range(0, 1) == 0);
      rx_fifo_rst = ($urandom_range(0, 99) == 0);
      din         = 8'($urandom);
      {bi_in, fe_in, pe_in} = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 299) == 0) fifo_en = ~fifo_en;
      if ($urandom_range(0, 63) == 0) rx_trig = 2'($urandom);
      if ($urandom_range(0, 127) == 0) {wls, pen, stb} = 4'($urandom);
      rst = ($urandom_range(0, 999) == 0);
      cyc();
    end

    fifo_en = 1; wls = 2'b00; pen = 0; stb = 0;
    for (int r = 0; r < 3; r++) begin
      push_ch(8'($urandom), 3'b000, 0);
      for (int i = 0; i < 700; i++) begin
        baud_pulse = ($urandom_range(0, 3) != 0);
        if (i == 200) {wls, pen, stb} = 4'($urandom);
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
